// File: rtl/cam_pe.sv
// Parametrised DATA_WIDTH x 2**ADDR_WIDTH CAM: per-entry valid bits, erase, sequenced flush,
// registered priority-encoded compare. Optional ternary compare mask under macro CAM_MASK_EN.
module cam_pe #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic                  Writ_Enable,
    input  logic [ADDR_WIDTH-1:0] WR_Addr,
    input  logic [DATA_WIDTH-1:0] Data_IN,
    input  logic                  Erase_Enable,
    input  logic                  Flush,
    input  logic                  CMP_Enable,
    input  logic [DATA_WIDTH-1:0] CMP_Din,
`ifdef CAM_MASK_EN
    input  logic [DATA_WIDTH-1:0] CMP_Mask,
`endif
    output logic                  Busy,
    output logic                  Match_Valid,
    output logic                  Match,
    output logic                  Multi_Match,
    output logic [ADDR_WIDTH-1:0] Match_Addr,
    output logic [ADDR_WIDTH:0]   Hit_Count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    busy_r;
    logic [DEPTH-1:0]        valid_r;
    logic [DATA_WIDTH-1:0]   data_r [DEPTH];

    logic                    match_valid_r;
    logic                    match_r;
    logic                    multi_match_r;
    logic [ADDR_WIDTH-1:0]   match_addr_r;
    logic [ADDR_WIDTH:0]     hit_count_r;

    logic [DATA_WIDTH-1:0]   care_s;
    logic [DEPTH-1:0]        match_vec_s;
    logic [ADDR_WIDTH-1:0]   match_addr_s;
    logic [ADDR_WIDTH:0]     hit_cnt_s;

    // Select which key bits take part in the compare.
    always_comb begin
`ifdef CAM_MASK_EN
        care_s = ~CMP_Mask;
`else
        care_s = {DATA_WIDTH{1'b1}};
`endif
    end

    // Match vector over current contents, lowest-index encoder and population count.
    always_comb begin
        match_vec_s  = {DEPTH{1'b0}};
        match_addr_s = {ADDR_WIDTH{1'b0}};
        hit_cnt_s    = {(ADDR_WIDTH+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_vec_s[i] = valid_r[i] &&
                             (((data_r[i] ^ CMP_Din) & care_s) == {DATA_WIDTH{1'b0}});
        end
        // Walking downward leaves the lowest matching index as the final value.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            match_addr_s = match_vec_s[i] ? ADDR_WIDTH'(i) : match_addr_s;
            hit_cnt_s    = hit_cnt_s + {{ADDR_WIDTH{1'b0}}, match_vec_s[i]};
        end
    end

    // Flush sequencer and valid-bit maintenance; flush clears win over erase, erase over write.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            state_r <= IDLE;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= {DEPTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (Erase_Enable) begin
                        valid_r[WR_Addr] <= 1'b0;
                    end else if (Writ_Enable) begin
                        valid_r[WR_Addr] <= 1'b1;
                    end else begin
                        valid_r <= valid_r;
                    end
                    if (Flush) begin
                        valid_r[0] <= 1'b0;
                        state_r    <= FLUSH;
                        cnt_r      <= {ADDR_WIDTH{1'b0}};
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                FLUSH: begin
                    valid_r[cnt_r] <= 1'b0;
                    if (cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {ADDR_WIDTH{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= {ADDR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Data array is deliberately left unreset; only the valid bits carry meaning.
    always_ff @(posedge Clk) begin
        if (Writ_Enable && !Erase_Enable && !busy_r) begin
            data_r[WR_Addr] <= Data_IN;
        end
    end

    // Registered compare results, held between compares.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            match_valid_r <= 1'b0;
            match_r       <= 1'b0;
            multi_match_r <= 1'b0;
            match_addr_r  <= {ADDR_WIDTH{1'b0}};
            hit_count_r   <= {(ADDR_WIDTH+1){1'b0}};
        end else if (CMP_Enable && !busy_r) begin
            match_valid_r <= 1'b1;
            match_r       <= |match_vec_s;
            multi_match_r <= (hit_cnt_s >= (ADDR_WIDTH+1)'(2));
            match_addr_r  <= match_addr_s;
            hit_count_r   <= hit_cnt_s;
        end else begin
            match_valid_r <= 1'b0;
        end
    end

    assign Busy        = busy_r;
    assign Match_Valid = match_valid_r;
    assign Match       = match_r;
    assign Multi_Match = multi_match_r;
    assign Match_Addr  = match_addr_r;
    assign Hit_Count   = hit_count_r;

endmodule

// File: tb/tb_cam_pe.sv
// Scoreboard bench for cam_pe (DATA_WIDTH=4, ADDR_WIDTH=2); the mask case runs when CAM_MASK_EN is defined.
module tb_cam_pe;

    typedef struct packed {
        logic       m;
        logic       mm;
        logic [1:0] a;
        logic [2:0] h;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rest = 1'b1;
    logic       Writ_Enable = 1'b0;
    logic [1:0] WR_Addr = 2'd0;
    logic [3:0] Data_IN = 4'd0;
    logic       Erase_Enable = 1'b0;
    logic       Flush = 1'b0;
    logic       CMP_Enable = 1'b0;
    logic [3:0] CMP_Din = 4'd0;
    logic [3:0] CMP_Mask = 4'd0;
    logic       Busy, Match_Valid, Match, Multi_Match;
    logic [1:0] Match_Addr;
    logic [2:0] Hit_Count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cycles;

    cam_pe #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
        .Clk(Clk), .Rest(Rest), .Writ_Enable(Writ_Enable), .WR_Addr(WR_Addr),
        .Data_IN(Data_IN), .Erase_Enable(Erase_Enable), .Flush(Flush),
        .CMP_Enable(CMP_Enable), .CMP_Din(CMP_Din),
`ifdef CAM_MASK_EN
        .CMP_Mask(CMP_Mask),
`endif
        .Busy(Busy), .Match_Valid(Match_Valid), .Match(Match),
        .Multi_Match(Multi_Match), .Match_Addr(Match_Addr), .Hit_Count(Hit_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every Match_Valid pulse must correspond to a queued expectation.
    always @(negedge Clk) begin
        if (Match_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_match_valid", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("match",       {7'd0, Match},       {7'd0, e.m});
                check("multi_match", {7'd0, Multi_Match}, {7'd0, e.mm});
                check("match_addr",  {6'd0, Match_Addr},  {6'd0, e.a});
                check("hit_count",   {5'd0, Hit_Count},   {5'd0, e.h});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        Writ_Enable  = 1'b0;
        Erase_Enable = 1'b0;
        Flush        = 1'b0;
        CMP_Enable   = 1'b0;
        CMP_Mask     = 4'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        Writ_Enable = 1'b1; WR_Addr = a; Data_IN = d;
        tick();
    endtask

    task automatic er(input logic [1:0] a);
        Erase_Enable = 1'b1; WR_Addr = a;
        tick();
    endtask

    task automatic cmp(input logic [3:0] key, input logic [3:0] mask, input logic m,
                       input logic mm, input logic [1:0] a, input logic [2:0] h);
        exp_t e;
        e.m = m; e.mm = mm; e.a = a; e.h = h;
        CMP_Enable = 1'b1; CMP_Din = key; CMP_Mask = mask;
        exp_q.push_back(e);
        tick();
    endtask

    initial begin
        #3;
        check("rst_busy",  {7'd0, Busy},        8'd0);
        check("rst_mv",    {7'd0, Match_Valid}, 8'd0);
        check("rst_match", {7'd0, Match},       8'd0);
        check("rst_multi", {7'd0, Multi_Match}, 8'd0);
        check("rst_addr",  {6'd0, Match_Addr},  8'd0);
        check("rst_hit",   {5'd0, Hit_Count},   8'd0);
        @(posedge Clk); #1;
        Rest = 1'b0;

        cmp(4'hA, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        wr(2'd2, 4'h5);
        cmp(4'h5, 4'h0, 1'b1, 1'b0, 2'd2, 3'd1);
        wr(2'd1, 4'h7);
        wr(2'd3, 4'h7);
        cmp(4'h7, 4'h0, 1'b1, 1'b1, 2'd1, 3'd2);
        er(2'd1);
        cmp(4'h7, 4'h0, 1'b1, 1'b0, 2'd3, 3'd1);
        // Same-edge write and compare sees old contents.
        Writ_Enable = 1'b1; WR_Addr = 2'd0; Data_IN = 4'h9;
        cmp(4'h9, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        cmp(4'h9, 4'h0, 1'b1, 1'b0, 2'd0, 3'd1);
        // Erase beats write at the same edge.
        Writ_Enable = 1'b1; Erase_Enable = 1'b1; WR_Addr = 2'd0; Data_IN = 4'h9;
        tick();
        cmp(4'h9, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        // Back-to-back compares.
        cmp(4'h5, 4'h0, 1'b1, 1'b0, 2'd2, 3'd1);
        cmp(4'h7, 4'h0, 1'b1, 1'b0, 2'd3, 3'd1);
        // All entries matching: hit count reaches DEPTH.
        for (int i = 0; i < 4; i++) wr(i[1:0], 4'h3);
        cmp(4'h3, 4'h0, 1'b1, 1'b1, 2'd0, 3'd4);
        wr(2'd2, 4'h5);
        wr(2'd3, 4'h7);

        // Flush: Busy must last exactly 4 cycles; write, compare and re-Flush inside are ignored.
        Flush = 1'b1;
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (Busy === 1'b1) begin
                busy_cycles++;
                if (busy_cycles == 2) Flush = 1'b1;
                if (busy_cycles == 4) begin
                    Writ_Enable = 1'b1; WR_Addr = 2'd1; Data_IN = 4'hA;
                    CMP_Enable = 1'b1; CMP_Din = 4'h5;
                end
            end
            tick();
        end
        check("flush_busy_cycles", 8'(busy_cycles), 8'd4);
        cmp(4'h3, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        cmp(4'h5, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        cmp(4'h7, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        cmp(4'hA, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);

        // Reset in the middle of a flush.
        wr(2'd2, 4'h5);
        wr(2'd3, 4'h7);
        cmp(4'h5, 4'h0, 1'b1, 1'b0, 2'd2, 3'd1);
        Flush = 1'b1;
        tick();
        tick();
        Rest = 1'b1;
        #1;
        check("rst_mid_busy",  {7'd0, Busy},       8'd0);
        check("rst_mid_match", {7'd0, Match},      8'd0);
        check("rst_mid_addr",  {6'd0, Match_Addr}, 8'd0);
        check("rst_mid_hit",   {5'd0, Hit_Count},  8'd0);
        @(posedge Clk); #1;
        Rest = 1'b0;
        check("post_rst_busy", {7'd0, Busy}, 8'd0);
        cmp(4'h5, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        cmp(4'h7, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0);
`ifdef CAM_MASK_EN
        wr(2'd2, 4'h5);
        wr(2'd3, 4'h7);
        cmp(4'h4, 4'h3, 1'b1, 1'b1, 2'd2, 3'd2);
`endif
        for (int i = 0; i < 4; i++) tick();
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
